mantissa_sub_seq: RTL and testbench
===================================

MANTISSA_SUB_SEQ -- requirements
Module: mantissa_sub_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 The block SHALL have derived localparam NUM_SLICE, equal to DATA_WIDTH/8, meaning the number of byte slices processed.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit: an operand request is presented.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port i_data_a, input, DATA_WIDTH bits: minuend.
REQ-008 The block SHALL have port i_data_b, input, DATA_WIDTH bits: subtrahend.
REQ-009 The block SHALL have port i_borrow, input, 1 bit: borrow-in.
REQ-010 The block SHALL have port o_valid, output, 1 bit: result is available.
REQ-011 The block SHALL have port i_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port o_diff, output, DATA_WIDTH bits: the result A - B - borrow, modulo 2^DATA_WIDTH.
REQ-013 The block SHALL have port o_borrow, output, 1 bit: borrow-out, meaning A < B + borrow as unsigned values.
REQ-014 The block SHALL have port o_zero, output, 1 bit: o_diff is all zeros.
REQ-015 The block SHALL have port o_busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-017 In IDLE, o_ready SHALL be 1; in CALC and DONE, o_ready SHALL be 0.
REQ-018 A handshake SHALL occur on a rising edge where i_valid=1 and o_ready=1.
  - i_data_a, i_data_b and i_borrow SHALL be registered at that edge.
  - The slice counter SHALL be cleared to 0.
  - The internal carry SHALL be set to ~i_borrow.
  - The state SHALL move to CALC.
REQ-019 Each CALC cycle k, for k = 0 to NUM_SLICE-1, SHALL process slice [8k+7:8k] and store it into o_diff[8k+7:8k].
  - Slice sum = A_k + ~B_k + carry.
  - The carry SHALL be updated with the slice carry-out.
REQ-020 The slice arithmetic SHALL be one 8-bit carry-lookahead add per cycle; there SHALL be no full-width combinational adder.
REQ-021 After slice NUM_SLICE-1, the state SHALL move to DONE on the same edge, with o_borrow = ~(final carry).
REQ-022 o_valid SHALL be 1 exactly in DONE, starting NUM_SLICE cycles after the accept edge.
REQ-023 o_diff, o_borrow and o_zero SHALL be registered outputs.
  - They SHALL hold stable throughout DONE and after leaving DONE, until the next accept.
  - o_zero SHALL reflect the complete o_diff and be valid whenever o_valid=1.
REQ-024 In DONE, when i_ready=1 at a rising edge, the state SHALL move to IDLE; when i_ready=0, the block SHALL remain in DONE indefinitely with the outputs unchanged.
REQ-025 There SHALL be no overlap: a new request SHALL be accepted no earlier than the cycle after the DONE-to-IDLE transition, so throughput is 1 operation per NUM_SLICE+2 cycles.
REQ-026 While o_ready=0, changes on i_valid, i_data_a, i_data_b or i_borrow SHALL have no effect.
REQ-027 With DATA_WIDTH=8 (NUM_SLICE=1), CALC SHALL last one cycle and the protocol SHALL be otherwise identical.
REQ-028 i_ready SHALL be ignored outside DONE.
REQ-029 o_busy SHALL be 1 in CALC and DONE, and 0 in IDLE.

Reset
REQ-030 Asserting i_rst_n=0 SHALL, asynchronously and in any state including mid-CALC, force the following, and the operation in progress SHALL be discarded with no o_valid produced:
  - state IDLE and slice counter 0;
  - o_valid=0 and o_busy=0;
  - o_diff=0 and o_borrow=0;
  - o_zero=1.
REQ-031 While i_rst_n=0, o_ready SHALL be 0; o_ready SHALL become 1 on the first rising edge after deassertion, and no request SHALL be accepted at that edge.

Verification
REQ-032 Basic subtract, DATA_WIDTH=32: A=0x0000_1000, B=0x0000_0001, borrow=0 -> o_valid exactly 4 cycles after accept; o_diff=0x0000_0FFF, o_borrow=0, o_zero=0.
REQ-033 Underflow with cross-slice borrow: A=0x0000_0000, B=0x0000_0001, borrow=0 -> o_diff=0xFFFF_FFFF, o_borrow=1; also A=0x0100_0000, B=0x00FF_FFFF -> o_diff=0x0000_0001, o_borrow=0.
REQ-034 Borrow-in and zero: A=0x8000_0001, B=0x8000_0000, borrow=1 -> o_diff=0, o_zero=1, o_borrow=0; A=B=0xFFFF_FFFF, borrow=1 -> o_diff=0xFFFF_FFFF, o_borrow=1.
REQ-035 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid stays 1 and outputs are stable; i_valid held high with new data is not accepted; the next accept occurs 1 cycle after i_ready=1.
REQ-036 Reset mid-operation: assert i_rst_n=0 two cycles into CALC -> immediately o_valid=0, o_busy=0, o_diff=0, o_zero=1; after release the next transaction completes correctly.
REQ-037 Random regression: at least 10k random A, B and borrow for DATA_WIDTH in {8, 24, 32, 64}, with random i_valid/i_ready gaps -> {o_borrow, o_diff} matches the reference model (A - B - borrow) and latency is always NUM_SLICE.

Source files
------------

// File: rtl/mantissa_sub_seq.sv
// Byte-serial subtractor: computes A - B - borrow one 8-bit slice per cycle,
// least significant slice first, behind a valid/ready handshake on both sides.
module mantissa_sub_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_borrow,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_diff,
  output logic                  o_borrow,
  output logic                  o_zero,
  output logic                  o_busy
);

  localparam int NUM_SLICE = DATA_WIDTH / 8;
  localparam int CNT_W     = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // 8-bit carry-lookahead add; every carry is a flat sum of generate/propagate terms.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pp;
    g    = a & b;
    p    = a ^ b;
    c    = 9'd0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_carry;
  logic [DATA_WIDTH-1:0] r_diff;
  logic                  r_borrow;
  logic                  r_zero;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_ready;

  logic                  w_accept;
  logic                  w_last;
  logic [CNT_W+2:0]      w_base;
  logic [7:0]            w_a_slice;
  logic [7:0]            w_b_slice;
  logic [8:0]            w_sum;
  logic [DATA_WIDTH-1:0] w_diff_upd;

  // r_ready is only ever set while in IDLE, so it alone qualifies an accept.
  assign w_accept  = i_valid & r_ready;
  assign w_last    = (r_cnt == LAST_SLICE);
  assign w_base    = {r_cnt, 3'b000};
  assign w_a_slice = r_a[w_base +: 8];
  assign w_b_slice = r_b[w_base +: 8];
  assign w_sum     = cla8(w_a_slice, ~w_b_slice, r_carry);

  // Current result with the slice being computed this cycle merged in.
  always_comb begin
    w_diff_upd                = r_diff;
    w_diff_upd[w_base +: 8]   = w_sum[7:0];
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = CALC;
        else          w_next_state = IDLE;
      end
      CALC: begin
        if (w_last) w_next_state = DONE;
        else        w_next_state = CALC;
      end
      DONE: begin
        if (i_ready) w_next_state = IDLE;
        else         w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Handshake flags registered from the next state; ready stays low until the first edge out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_valid <= (w_next_state == DONE);
      r_busy  <= (w_next_state != IDLE);
      r_ready <= (w_next_state == IDLE);
    end
  end

  // Operand capture and slice-serial datapath; results hold until the next accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_a      <= {DATA_WIDTH{1'b0}};
      r_b      <= {DATA_WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_diff   <= {DATA_WIDTH{1'b0}};
      r_borrow <= 1'b0;
      r_zero   <= 1'b1;
    end else if ((r_state == IDLE) && w_accept) begin
      r_a     <= i_data_a;
      r_b     <= i_data_b;
      r_carry <= ~i_borrow;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (r_state == CALC) begin
      r_diff  <= w_diff_upd;
      r_zero  <= (w_diff_upd == {DATA_WIDTH{1'b0}});
      r_carry <= w_sum[8];
      if (w_last) begin
        r_borrow <= ~w_sum[8];
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_mantissa_sub_seq.sv
// Bench for mantissa_sub_seq: directed vectors on a 32-bit instance plus
// parallel random streams on 8/24/32/64-bit instances against an arithmetic model.
module tb_mantissa_sub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [63:0] a_in   [4];
  logic [63:0] b_in   [4];
  logic        bi_in  [4];
  logic        vld_in [4];
  logic        rdy_in [4];
  logic        o_rdy  [4];
  logic        o_vld  [4];
  logic        o_bo   [4];
  logic        o_z    [4];
  logic        o_busy [4];
  logic [63:0] o_d    [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : (g == 1) ? 24 : (g == 2) ? 32 : 64;
    logic [W-1:0] d_w;
    mantissa_sub_seq #(.DATA_WIDTH(W)) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (vld_in[g]),
      .o_ready  (o_rdy[g]),
      .i_data_a (a_in[g][W-1:0]),
      .i_data_b (b_in[g][W-1:0]),
      .i_borrow (bi_in[g]),
      .o_valid  (o_vld[g]),
      .i_ready  (rdy_in[g]),
      .o_diff   (d_w),
      .o_borrow (o_bo[g]),
      .o_zero   (o_z[g]),
      .o_busy   (o_busy[g])
    );
    assign o_d[g] = 64'(d_w);
  end

  function automatic int wid(input int idx);
    case (idx)
      0:       return 8;
      1:       return 24;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int idx);
    if (wid(idx) == 64) return {64{1'b1}};
    else                return (64'd1 << wid(idx)) - 64'd1;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s w%0d: got %0h expected %0h", name, wid(idx), act, exp);
  endtask

  // Reference: plain unsigned arithmetic on zero-extended operands.
  task automatic model(input int idx, input logic [63:0] a, input logic [63:0] b, input logic bi,
                       output logic [63:0] d, output logic bo, output logic z);
    logic [65:0] av;
    logic [65:0] bv;
    logic [65:0] r;
    logic [63:0] m;
    m  = wmask(idx);
    av = {2'b00, a & m};
    bv = {2'b00, b & m};
    r  = av - bv - {65'd0, bi};
    d  = r[63:0] & m;
    bo = (av < (bv + {65'd0, bi}));
    z  = (d == 64'd0);
  endtask

  task automatic start_op(input int idx, input logic [63:0] a, input logic [63:0] b, input logic bi);
    int t;
    t = 0;
    a_in[idx] = a; b_in[idx] = b; bi_in[idx] = bi; vld_in[idx] = 1'b1;
    while (o_rdy[idx] !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_wait", idx, 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    vld_in[idx] = 1'b0;
    a_in[idx]   = {$urandom, $urandom};
    b_in[idx]   = {$urandom, $urandom};
    bi_in[idx]  = 1'($urandom_range(0, 1));
    chk("busy_after_accept", idx, 64'(o_busy[idx]), 64'd1);
    chk("ready_after_accept", idx, 64'(o_rdy[idx]), 64'd0);
  endtask

  task automatic wait_done(input int idx, input logic [63:0] ed, input logic eb, input logic ez);
    int lat;
    lat = 0;
    while (o_vld[idx] !== 1'b1 && lat < 100) begin
      rdy_in[idx] = 1'($urandom_range(0, 1));
      vld_in[idx] = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    rdy_in[idx] = 1'b0;
    vld_in[idx] = 1'b0;
    chk("latency", idx, 64'(lat), 64'(wid(idx) / 8));
    chk("diff", idx, o_d[idx], ed);
    chk("borrow", idx, 64'(o_bo[idx]), 64'(eb));
    chk("zero", idx, 64'(o_z[idx]), 64'(ez));
    chk("ready_in_done", idx, 64'(o_rdy[idx]), 64'd0);
  endtask

  task automatic hold_release(input int idx, input int gap, input logic [63:0] ed, input logic eb, input logic ez);
    repeat (gap) begin
      @(posedge clk); #1;
      chk("hold_valid", idx, 64'(o_vld[idx]), 64'd1);
      chk("hold_diff", idx, o_d[idx], ed);
      chk("hold_borrow", idx, 64'(o_bo[idx]), 64'(eb));
    end
    rdy_in[idx] = 1'b1;
    @(posedge clk); #1;
    rdy_in[idx] = 1'b0;
    chk("valid_drop", idx, 64'(o_vld[idx]), 64'd0);
    chk("busy_drop", idx, 64'(o_busy[idx]), 64'd0);
    chk("diff_kept", idx, o_d[idx], ed);
    chk("zero_kept", idx, 64'(o_z[idx]), 64'(ez));
  endtask

  task automatic run_op(input int idx, input logic [63:0] a, input logic [63:0] b, input logic bi,
                        input int pre_gap, input int gap);
    logic [63:0] ed;
    logic        eb;
    logic        ez;
    model(idx, a, b, bi, ed, eb, ez);
    repeat (pre_gap) begin
      vld_in[idx] = 1'b0;
      rdy_in[idx] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start_op(idx, a, b, bi);
    wait_done(idx, ed, eb, ez);
    hold_release(idx, gap, ed, eb, ez);
  endtask

  task automatic rand_stream(input int idx, input int n);
    logic [63:0] a;
    logic [63:0] b;
    logic        bi;
    for (int k = 0; k < n; k++) begin
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      bi = 1'($urandom_range(0, 1));
      run_op(idx, a, b, bi, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic [31:0] d;
    logic        bo;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0100_0000, 32'h00FF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0001, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h0204_0608, 1'b0, 32'h1030_5070, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b0, 1'b1};

    for (int i = 0; i < 4; i++) begin
      a_in[i] = 64'd0; b_in[i] = 64'd0; bi_in[i] = 1'b0; vld_in[i] = 1'b0; rdy_in[i] = 1'b0;
    end
    vld_in[2] = 1'b1;

    // Reset state, and no accept on the first edge after release.
    #2 rst_n = 1'b0;
    #20;
    chk("rst_ready", 2, 64'(o_rdy[2]), 64'd0);
    chk("rst_valid", 2, 64'(o_vld[2]), 64'd0);
    chk("rst_busy", 2, 64'(o_busy[2]), 64'd0);
    chk("rst_diff", 2, o_d[2], 64'd0);
    chk("rst_borrow", 2, 64'(o_bo[2]), 64'd0);
    chk("rst_zero", 2, 64'(o_z[2]), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 2, 64'(o_rdy[2]), 64'd1);
    chk("no_accept_at_release", 2, 64'(o_busy[2]), 64'd0);
    vld_in[2] = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(2, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].bi);
      wait_done(2, 64'(vecs[i].d), vecs[i].bo, vecs[i].z);
      hold_release(2, 1, 64'(vecs[i].d), vecs[i].bo, vecs[i].z);
    end

    // Backpressure with a new request held pending on i_valid.
    start_op(2, 64'h0000_1000, 64'h0000_0001, 1'b0);
    wait_done(2, 64'h0000_0FFF, 1'b0, 1'b0);
    vld_in[2] = 1'b1; a_in[2] = 64'h5555_5555; b_in[2] = 64'h1111_1111; bi_in[2] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", 2, 64'(o_vld[2]), 64'd1);
      chk("bp_diff", 2, o_d[2], 64'h0000_0FFF);
      chk("bp_no_accept", 2, 64'(o_rdy[2]), 64'd0);
    end
    rdy_in[2] = 1'b1;
    @(posedge clk); #1;
    rdy_in[2] = 1'b0;
    chk("bp_idle_valid", 2, 64'(o_vld[2]), 64'd0);
    chk("bp_ready_back", 2, 64'(o_rdy[2]), 64'd1);
    @(posedge clk); #1;
    vld_in[2] = 1'b0;
    chk("bp_accept_next", 2, 64'(o_busy[2]), 64'd1);
    wait_done(2, 64'h4444_4443, 1'b0, 1'b0);
    hold_release(2, 0, 64'h4444_4443, 1'b0, 1'b0);

    // Reset two cycles into CALC discards the operation.
    start_op(2, 64'h0000_00FF, 64'h0000_0001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 2, 64'(o_vld[2]), 64'd0);
    chk("mid_rst_busy", 2, 64'(o_busy[2]), 64'd0);
    chk("mid_rst_diff", 2, o_d[2], 64'd0);
    chk("mid_rst_zero", 2, 64'(o_z[2]), 64'd1);
    chk("mid_rst_ready", 2, 64'(o_rdy[2]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid_after", 2, 64'(o_vld[2]), 64'd0);
    run_op(2, 64'h0000_00FF, 64'h0000_0001, 1'b0, 0, 1);

    fork
      rand_stream(0, 2500);
      rand_stream(1, 2500);
      rand_stream(2, 2500);
      rand_stream(3, 2500);
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
